com_dec_fsm_multibank: RTL

Parametrised command decoder for the vector coprocessor. It accepts opcode bytes from the UART receive path with a valid strobe and decodes them into an operation code plus a one-hot/multi-hot bank-enable vector for NUM_BANKS vector memories. It holds the operation until the datapath reports completion. Compared with the two-bank decoder it adds a two-byte indexed read/write, a valid handshake, an illegal-command flag and an optional completion watchdog.

---
 rtl/com_dec_fsm_multibank.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/com_dec_fsm_multibank.sv
`default_nettype none
// ============================================================================
// Module   : com_dec_fsm_multibank
// Purpose  : Command decoder for the vector coprocessor. Turns opcode bytes
//            from the UART receive path into an operation code and a
//            per-bank enable vector, and holds them until the datapath
//            signals completion. Indexed commands (105/106) take a second
//            byte selecting a single bank.
// Ports    : clk          - system clock, rising edge
//            rst          - asynchronous active-high reset
//            data_in[7:0] - command / argument byte
//            data_valid   - one-cycle strobe qualifying data_in
//            op_finished  - datapath completion pulse (used in RUN only)
//            op[7:0]      - active operation code, 0 when idle
//            bank_en      - per-bank enable, NUM_BANKS wide
//            busy         - high in every state except IDLE
//            cmd_err      - one-cycle pulse on illegal opcode / bank index
//            timeout      - one-cycle pulse on watchdog expiry
// Options  : COM_DEC_TIMEOUT_EN - enables the RUN-state watchdog; when not
//            defined, timeout is tied low and RUN waits indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module com_dec_fsm_multibank #(
    parameter int NUM_BANKS      = 2,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           data_in,
    input  logic                 data_valid,
    input  logic                 op_finished,
    output logic [7:0]           op,
    output logic [NUM_BANKS-1:0] bank_en,
    output logic                 busy,
    output logic                 cmd_err,
    output logic                 timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARG  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                r_state, w_state_next;
    logic [7:0]            r_arg_op, w_arg_op_next;
    logic [7:0]            r_op, w_op_next;
    logic [NUM_BANKS-1:0]  r_bank, w_bank_next;
    logic                  r_busy, w_busy_next;
    logic                  r_err, w_err_next;
    logic                  r_tmo, w_tmo_next;
    logic                  w_expire;

`ifdef COM_DEC_TIMEOUT_EN
    localparam int                 c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Expiry is flagged during the last allowed RUN cycle so the counter
    // reaches TIMEOUT_CYCLES on the same edge that leaves RUN.
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((w_state_next == S_RUN) && (r_state != S_RUN)) begin
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign w_expire = (r_state == S_RUN) && (r_cnt == c_LIMIT);
`else
    assign w_expire = 1'b0;
`endif

    // State and all outputs are registered together so every output
    // changes on the edge that performs the transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_arg_op <= '0;
            r_op     <= '0;
            r_bank   <= '0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_arg_op <= w_arg_op_next;
            r_op     <= w_op_next;
            r_bank   <= w_bank_next;
            r_busy   <= w_busy_next;
            r_err    <= w_err_next;
            r_tmo    <= w_tmo_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_arg_op_next = r_arg_op;
        w_op_next     = r_op;
        w_bank_next   = r_bank;
        w_err_next    = 1'b0;
        w_tmo_next    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (data_valid) begin
                    case (data_in)
                        8'd97, 8'd99: begin
                            w_state_next   = S_RUN;
                            w_op_next      = data_in;
                            w_bank_next    = '0;
                            w_bank_next[0] = 1'b1;
                        end
                        8'd98, 8'd100: begin
                            w_state_next   = S_RUN;
                            w_op_next      = data_in;
                            w_bank_next    = '0;
                            w_bank_next[1] = 1'b1;
                        end
                        8'd101, 8'd102, 8'd103, 8'd104: begin
                            w_state_next   = S_RUN;
                            w_op_next      = data_in;
                            w_bank_next    = '0;
                            w_bank_next[0] = 1'b1;
                            w_bank_next[1] = 1'b1;
                        end
                        8'd105, 8'd106: begin
                            w_state_next  = S_ARG;
                            w_arg_op_next = data_in;
                        end
                        8'd0: begin
                            // Padding byte: silently ignored.
                        end
                        default: begin
                            w_err_next = 1'b1;
                        end
                    endcase
                end
            end

            S_ARG: begin
                if (data_valid) begin
                    if (int'(data_in) < NUM_BANKS) begin
                        w_state_next = S_RUN;
                        w_op_next    = r_arg_op;
                        for (int i = 0; i < NUM_BANKS; i++) begin
                            w_bank_next[i] = (int'(data_in) == i);
                        end
                    end else begin
                        w_state_next = S_IDLE;
                        w_err_next   = 1'b1;
                    end
                end
            end

            S_RUN: begin
                // Completion takes priority over a coincident expiry.
                if (op_finished) begin
                    w_state_next = S_IDLE;
                    w_op_next    = '0;
                    w_bank_next  = '0;
                end else if (w_expire) begin
                    w_state_next = S_IDLE;
                    w_op_next    = '0;
                    w_bank_next  = '0;
                    w_tmo_next   = 1'b1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_op_next    = '0;
                w_bank_next  = '0;
            end
        endcase

        w_busy_next = (w_state_next != S_IDLE);
    end

    assign op      = r_op;
    assign bank_en = r_bank;
    assign busy    = r_busy;
    assign cmd_err = r_err;
    assign timeout = r_tmo;

endmodule
`default_nettype wire
